sprite_compositor: RTL

//  Downstream consumer of the sprite address transformer. Takes its {addr, valid} per screen

---
 rtl/sprite_pkg.sv | 11 +
 rtl/delay_line.sv | 27 ++
 rtl/sprite_compositor.sv | 96 +++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared pixel type and default colour-key / sync-polarity values for the
// sprite compositing path.
package sprite_pkg;

  localparam int           PIX_WIDTH     = 12;
  localparam logic [11:0]  COLOR_KEY_DEF = 12'h0F0;
  localparam logic         SYNC_POL_DEF  = 1'b0;

  typedef logic [PIX_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register whose every stage resets to a caller-chosen
// value, so sync bits can idle at their inactive level.
module delay_line #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sprite_compositor.sv
// Fetches sprite texels, aligns video timing to ROM latency, colour-key
// composites over the background and reports per-frame hazard collisions.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int                AWIDTH      = 16,
  parameter int                PWIDTH      = PIX_WIDTH,
  parameter int                ROM_LATENCY = 2,
  parameter logic [PWIDTH-1:0] COLOR_KEY   = COLOR_KEY_DEF,
  parameter logic              SYNC_POL    = SYNC_POL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic              in_valid,
  input  logic              in_de,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic [PWIDTH-1:0] bg_pixel,
  input  logic              bg_hazard,
  output logic [AWIDTH-1:0] rom_addr,
  output logic              rom_en,
  input  logic [PWIDTH-1:0] rom_data,
  output logic [PWIDTH-1:0] out_pixel,
  output logic              out_de,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              collision,
  output logic              collision_stb
);

  localparam int               BUS_W    = PWIDTH + 5;
  localparam logic [BUS_W-1:0] BUS_INIT = {2'b00, ~SYNC_POL, ~SYNC_POL, 1'b0, {PWIDTH{1'b0}}};

  function automatic logic opaque(input logic [PWIDTH-1:0] texel);
    return texel != COLOR_KEY;
  endfunction

  logic [BUS_W-1:0]  bus_p0, bus_p1;
  logic              vld_p1, de_p1, hsync_p1, vsync_p1, hazard_p1;
  logic [PWIDTH-1:0] bg_p1;
  logic              opaque_p1, hit_p1, frame_end_p1;
  logic              accum;

  assign rom_addr = in_addr;
  assign rom_en   = in_valid & in_de;

  // p0 -> p1: side-band delayed to meet rom_data
  assign bus_p0 = {in_valid, in_de, in_hsync, in_vsync, bg_hazard, bg_pixel};

  delay_line #(
    .WIDTH (BUS_W),
    .DEPTH (ROM_LATENCY),
    .INIT  (BUS_INIT)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (bus_p0),
    .dout (bus_p1)
  );

  assign {vld_p1, de_p1, hsync_p1, vsync_p1, hazard_p1, bg_p1} = bus_p1;

  assign opaque_p1    = opaque(rom_data);
  assign hit_p1       = de_p1 & vld_p1 & opaque_p1 & hazard_p1;
  // out_vsync holds the previous vsync_p1, which gives the edge detect for free
  assign frame_end_p1 = (vsync_p1 == SYNC_POL) && (out_vsync != SYNC_POL);

  // p1 -> output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pixel     <= '0;
      out_de        <= 1'b0;
      out_hsync     <= ~SYNC_POL;
      out_vsync     <= ~SYNC_POL;
      collision     <= 1'b0;
      collision_stb <= 1'b0;
      accum         <= 1'b0;
    end else begin
      out_de    <= de_p1;
      out_hsync <= hsync_p1;
      out_vsync <= vsync_p1;
      if (!de_p1)                     out_pixel <= '0;
      else if (vld_p1 && opaque_p1)   out_pixel <= rom_data;
      else                            out_pixel <= bg_p1;
      collision_stb <= frame_end_p1;
      if (frame_end_p1) begin
        collision <= accum | hit_p1;
        accum     <= 1'b0;
      end else if (hit_p1) begin
        accum <= 1'b1;
      end
    end
  end

endmodule
